// File: rtl/axil_reg_responder.sv
// AXI4-lite slave exposing a bank of byte-writable registers.
// Independent write and read paths, one-entry request buffers, registered responses.
module axil_reg_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int REG_COUNT  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int SHIFT = $clog2(STRB_WIDTH);
    localparam int IDX_W = ADDR_WIDTH - SHIFT;
    localparam logic [IDX_W:0] REG_LIM = (IDX_W + 1)'(REG_COUNT);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic                  active;
    logic                  aw_full;
    logic                  w_full;
    logic                  ar_full;
    logic [IDX_W-1:0]      aw_idx;
    logic [IDX_W-1:0]      ar_idx;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [DATA_WIDTH-1:0] rd_word;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;
    logic rd_fire;
    logic aw_ok;
    logic ar_ok;
    logic unused_bits;

    assign unused_bits = ^{s_axil_awprot, s_axil_arprot,
                           s_axil_awaddr, s_axil_araddr};

    assign s_axil_awready = active & ~aw_full;
    assign s_axil_wready  = active & ~w_full;
    assign s_axil_arready = active & ~ar_full;

    assign aw_hs   = s_axil_awvalid & s_axil_awready;
    assign w_hs    = s_axil_wvalid & s_axil_wready;
    assign ar_hs   = s_axil_arvalid & s_axil_arready;
    assign commit  = aw_full & w_full & (~s_axil_bvalid | s_axil_bready);
    assign rd_fire = ar_full & (~s_axil_rvalid | s_axil_rready);
    assign aw_ok   = {1'b0, aw_idx} < REG_LIM;
    assign ar_ok   = {1'b0, ar_idx} < REG_LIM;

    // Out-of-range indices match no register and read back as zero
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_word = regs[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active        <= 1'b0;
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_idx        <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axil_bvalid <= 1'b0;
            s_axil_bresp  <= OKAY;
        end else begin
            active <= 1'b1;
            if (aw_hs) begin
                aw_idx <= s_axil_awaddr[ADDR_WIDTH-1:SHIFT];
            end
            if (w_hs) begin
                w_data <= s_axil_wdata;
                w_strb <= s_axil_wstrb;
            end
            if (commit) begin
                aw_full <= 1'b0;
            end else if (aw_hs) begin
                aw_full <= 1'b1;
            end
            if (commit) begin
                w_full <= 1'b0;
            end else if (w_hs) begin
                w_full <= 1'b1;
            end
            if (commit) begin
                s_axil_bvalid <= 1'b1;
                s_axil_bresp  <= aw_ok ? OKAY : SLVERR;
            end else if (s_axil_bready) begin
                s_axil_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && aw_ok) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                for (int b = 0; b < STRB_WIDTH; b++) begin
                    if (aw_idx == IDX_W'(i) && w_strb[b]) begin
                        regs[i][8*b +: 8] <= w_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // Read samples regs before a same-edge commit lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_full       <= 1'b0;
            ar_idx        <= '0;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
            s_axil_rresp  <= OKAY;
        end else begin
            if (ar_hs) begin
                ar_idx <= s_axil_araddr[ADDR_WIDTH-1:SHIFT];
            end
            if (rd_fire) begin
                ar_full <= 1'b0;
            end else if (ar_hs) begin
                ar_full <= 1'b1;
            end
            if (rd_fire) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= ar_ok ? rd_word : '0;
                s_axil_rresp  <= ar_ok ? OKAY : SLVERR;
            end else if (s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

endmodule
